// File: rtl/inst_fetch.sv
// Instruction fetch initiator: owns the PC, drives the combinational instruction ROM,
// and buffers fetched {pc, inst} pairs in order toward decode over valid/ready.

module inst_fetch_entry (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);
  logic [31:0] pc_q, inst_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= '0;
      inst_q <= '0;
    end else if (we_i) begin
      pc_q   <= pc_i;
      inst_q <= inst_i;
    end
  end

  assign pc_o   = pc_q;
  assign inst_o = inst_q;
endmodule

module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  input  logic        id_ready_i
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic          run_q, run_d;
  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic                   push, pop, space;
  logic [DEPTH-1:0]       ent_we;
  logic [DEPTH-1:0][31:0] ent_pc, ent_inst;
  logic                   unused_lo;

  assign unused_lo = ^redirect_pc_i[1:0];

  // A pop frees a slot in the same cycle, so a full buffer still streams at 1/cycle.
  assign pop        = if_valid_o & id_ready_i;
  assign space      = (count_q < CW'(DEPTH)) | pop;
  assign rom_ce_o   = run_q & space & ~redirect_i;
  assign push       = rom_ce_o;
  assign rom_addr_o = pc_q;

  assign if_valid_o = (count_q != '0) & ~redirect_i;
  assign if_pc_o    = (count_q != '0) ? ent_pc[rd_ptr_q]   : '0;
  assign if_inst_o  = (count_q != '0) ? ent_inst[rd_ptr_q] : '0;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign ent_we[g] = push & (wr_ptr_q == PW'(g));
    inst_fetch_entry u_ent (
      .clk    (clk),
      .rst    (rst),
      .we_i   (ent_we[g]),
      .pc_i   (pc_q),
      .inst_i (rom_inst_i),
      .pc_o   (ent_pc[g]),
      .inst_o (ent_inst[g])
    );
  end

  always_comb begin
    run_d    = 1'b1;
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_i) begin
      // Redirect also lands while stopped; push/pop are already gated off by it.
      pc_d     = {redirect_pc_i[31:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q    <= 1'b0;
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      run_q    <= run_d;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboarded bench for inst_fetch: the stimulus pushes the expected pc stream on every
// restart, and a negedge monitor pops and compares each delivered instruction.

module tb_inst_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam int          QLEN     = 1000;

  logic        clk, rst;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o, rom_inst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o, if_inst_o;
  logic        id_ready_i;

  int          errs, checks;
  logic [31:0] exp_q[$];
  logic [31:0] base_pc;
  int          n_popped;

  inst_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_ce_o      (rom_ce_o),
    .rom_addr_o    (rom_addr_o),
    .rom_inst_i    (rom_inst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .if_valid_o    (if_valid_o),
    .if_pc_o       (if_pc_o),
    .if_inst_o     (if_inst_o),
    .id_ready_i    (id_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  assign rom_inst_i = rom(rom_addr_o);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Fetch restarts at pc: decode must then see pc, pc+4, ... in order.
  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    base_pc = pc;
    for (int i = 0; i < QLEN; i++) exp_q.push_back(pc + 32'(4 * i));
  endtask

  task automatic progress(input string nm, input int start, input int n);
    chk(nm, 32'(n_popped - start >= n), 32'd1);
  endtask

  // Monitor: occupancy = fetched - delivered since the last restart.
  int          fetched, delivered, occ;
  bit          run_m, pop_m;
  logic [31:0] e;

  always @(negedge clk) begin
    if (!rst) begin
      run_m = 1'b0; fetched = 0; delivered = 0;
    end else begin
      occ   = fetched - delivered;
      pop_m = if_valid_o && id_ready_i;
      chk("occ_max", 32'(occ <= DEPTH), 32'd1);
      chk("valid", 32'(if_valid_o), 32'(occ != 0 && !redirect_i));
      chk("ce", 32'(rom_ce_o), 32'(run_m && (occ < DEPTH || pop_m) && !redirect_i));
      if (rom_ce_o) chk("fetch_addr", rom_addr_o, base_pc + 32'(4 * fetched));
      if (occ == 0) begin
        chk("idle_pc", if_pc_o, 32'd0);
        chk("idle_inst", if_inst_o, 32'd0);
      end
      if (pop_m) begin
        n_popped++;
        if (exp_q.size() == 0) chk("unexpected_delivery", if_pc_o, 32'hxxxx_xxxx);
        else begin
          e = exp_q.pop_front();
          chk("if_pc", if_pc_o, e);
          chk("if_inst", if_inst_o, rom(e));
        end
      end
      if (redirect_i) begin
        fetched = 0; delivered = 0;
      end else begin
        fetched += int'(rom_ce_o);
        delivered += int'(pop_m);
      end
      run_m = 1'b1;
    end
  end

  int  snap;
  bit  seen;
  logic [31:0] rp;

  initial begin
    errs = 0; checks = 0; n_popped = 0;
    rst = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; id_ready_i = 1'b1;
    restart(RESET_PC);
    #12;
    chk("rst_ce", 32'(rom_ce_o), 32'd0);
    chk("rst_addr", rom_addr_o, RESET_PC);
    chk("rst_valid", 32'(if_valid_o), 32'd0);
    chk("rst_pc", if_pc_o, 32'd0);
    chk("rst_inst", if_inst_o, 32'd0);

    // Startup latency: run on edge 1, fetch RESET_PC in the next cycle, valid after edge 2.
    @(posedge clk); #1 rst = 1'b1;
    snap = n_popped;
    @(posedge clk); @(negedge clk);
    chk("lat_ce", 32'(rom_ce_o), 32'd1);
    chk("lat_novalid", 32'(if_valid_o), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("lat_valid", 32'(if_valid_o), 32'd1);
    chk("lat_pc", if_pc_o, RESET_PC);
    repeat (8) @(posedge clk);
    progress("stream_progress", snap, 8);

    // Backpressure from the first valid, then redirect while holding pcs 8 and C.
    @(posedge clk); #1 rst = 1'b0; id_ready_i = 1'b0; restart(RESET_PC);
    @(posedge clk); #1 rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = if_valid_o;
    end
    chk("bp_first_valid_timeout", 32'(seen), 32'd1);
    repeat (4) @(negedge clk);
    chk("bp_full_ce", 32'(rom_ce_o), 32'd0);
    chk("bp_full_valid", 32'(if_valid_o), 32'd1);
    chk("bp_hold_pc", if_pc_o, 32'd0);
    @(posedge clk); #1 id_ready_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 id_ready_i = 1'b0;
    @(negedge clk);
    chk("bp_head_8", if_pc_o, 32'h8);
    chk("bp_full_ce2", 32'(rom_ce_o), 32'd0);
    @(posedge clk); #1 redirect_i = 1'b1; redirect_pc_i = 32'h0000_0102; id_ready_i = 1'b1;
    restart(32'h0000_0100);
    @(negedge clk);
    chk("redir_valid", 32'(if_valid_o), 32'd0);
    @(posedge clk); #1 redirect_i = 1'b0;
    @(negedge clk);
    chk("redir_gap", 32'(if_valid_o), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("redir_lat_valid", 32'(if_valid_o), 32'd1);
    chk("redir_lat_pc", if_pc_o, 32'h0000_0100);

    // Toggling ready keeps the full buffer moving.
    snap = n_popped;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1 id_ready_i = i[0];
    end
    progress("toggle_progress", snap, 8);

    // Address wrap.
    @(posedge clk); #1 redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8; id_ready_i = 1'b1;
    restart(32'hFFFF_FFF8);
    snap = n_popped;
    @(posedge clk); #1 redirect_i = 1'b0;
    repeat (6) @(posedge clk);
    progress("wrap_progress", snap, 3);

    // Asynchronous reset between edges while streaming.
    @(posedge clk); #3 rst = 1'b0;
    #1;
    chk("arst_ce", 32'(rom_ce_o), 32'd0);
    chk("arst_valid", 32'(if_valid_o), 32'd0);
    chk("arst_addr", rom_addr_o, RESET_PC);
    chk("arst_pc", if_pc_o, 32'd0);
    restart(RESET_PC);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    snap = n_popped;
    repeat (6) @(posedge clk);
    progress("arst_progress", snap, 3);

    // Random ready and redirects, including back-to-back and near-wrap targets.
    snap = n_popped;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      id_ready_i = ($urandom % 4) != 0;
      if ($urandom % 25 == 0) begin
        rp = ($urandom % 3 == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : 32'($urandom);
        redirect_i = 1'b1; redirect_pc_i = rp;
        restart({rp[31:2], 2'b00});
      end else redirect_i = 1'b0;
    end
    @(posedge clk); #1 redirect_i = 1'b0;
    repeat (4) @(posedge clk);
    progress("rand_progress", snap, 100);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
